// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide scheduler.
//   md_op_e        - E-stage operation encoding (MD_NONE = 0)
//   MD_*_CYCLES    - default busy latencies for mult/multu and div/divu
//   md_is_start_op - true for the operations that occupy the unit
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    function automatic logic md_is_start_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: down-counter that tracks how long the HI/LO unit is occupied.
//   clk, reset  - clock, synchronous active-high reset
//   load_i      - load strobe (operation starts this cycle)
//   load_val_i  - latency to load (number of busy cycles, >= 1)
//   busy_o      - counter non-zero: operation in flight
//   commit_o    - last busy cycle: results are written at this edge
module md_busy_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             busy_o,
    output logic             commit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign busy_o   = (cnt_q != '0);
    assign commit_o = (cnt_q == CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (busy_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning the architectural HI/LO registers.
//   clk, reset - clock, synchronous active-high reset
//   E_op       - E-stage operation (md_pkg::md_op_e encoding)
//   E_A, E_B   - forwarded rs / rt operands
//   E_flush    - E-stage instruction cancelled this cycle
//   D_md_use   - D-stage instruction touches HI/LO
//   busy       - operation in flight
//   md_stall   - stall request for the D/E pipeline registers
//   HI, LO     - architectural HI/LO (registered)
// Build option: MD_DIVZERO_FAST_EN - divide by zero occupies the unit for a
// single cycle instead of DIV_CYCLES.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_flush,
    input  logic        D_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_op_e op;
    logic   start;
    logic   mt_wr;
    logic   commit;
    logic   div_zero;

    logic [CNT_W-1:0] load_val;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic signed [63:0] mul_sa, mul_sb, mul_sp;
    logic        [63:0] mul_up;
    logic               sdiv_ovf;
    logic signed [31:0] sdiv_a, sdiv_b, sdiv_q, sdiv_r;
    logic        [31:0] udiv_b, udiv_q, udiv_r;
    logic        [31:0] res_hi, res_lo;

    assign op = md_op_e'(E_op);

    assign start = md_is_start_op(op) & ~E_flush & ~busy;
    assign mt_wr = ((op == MD_MTHI) || (op == MD_MTLO)) & ~E_flush & ~busy;

    assign div_zero = (E_B == '0);

    assign md_stall = D_md_use & (busy | start);

    assign HI = hi_q;
    assign LO = lo_q;

    // Arithmetic for the operation being issued this cycle.
    always_comb begin
        mul_sa = {{32{E_A[31]}}, E_A};
        mul_sb = {{32{E_B[31]}}, E_B};
        mul_sp = mul_sa * mul_sb;
        mul_up = {32'd0, E_A} * {32'd0, E_B};

        // A divisor of 1 covers both zero (result discarded anyway) and the
        // 0x80000000 / -1 overflow, whose required answer is exactly A / 1.
        sdiv_ovf = (E_A == 32'h8000_0000) && (E_B == '1);
        sdiv_a   = E_A;
        sdiv_b   = (div_zero || sdiv_ovf) ? 32'sd1 : E_B;
        sdiv_q   = sdiv_a / sdiv_b;
        sdiv_r   = sdiv_a % sdiv_b;

        udiv_b = div_zero ? 32'd1 : E_B;
        udiv_q = E_A / udiv_b;
        udiv_r = E_A % udiv_b;

        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  begin res_hi = mul_sp[63:32]; res_lo = mul_sp[31:0]; end
            MD_MULTU: begin res_hi = mul_up[63:32]; res_lo = mul_up[31:0]; end
            MD_DIV:   begin res_hi = sdiv_r;        res_lo = sdiv_q;       end
            MD_DIVU:  begin res_hi = udiv_r;        res_lo = udiv_q;       end
            default:  begin res_hi = '0;            res_lo = '0;           end
        endcase
    end

    // Busy latency for the operation being issued.
    always_comb begin
        load_val = CNT_W'(MULT_CYCLES);
        if ((op == MD_DIV) || (op == MD_DIVU)) begin
`ifdef MD_DIVZERO_FAST_EN
            load_val = div_zero ? CNT_W'(1) : CNT_W'(DIV_CYCLES);
`else
            load_val = CNT_W'(DIV_CYCLES);
`endif
        end
    end

    md_busy_cnt #(
        .CNT_W (CNT_W)
    ) u_busy_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start),
        .load_val_i (load_val),
        .busy_o     (busy),
        .commit_o   (commit)
    );

    // Pending result and HI/LO update. start, mt_wr and commit are mutually
    // exclusive: the first two require ~busy, commit only occurs while busy.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        if (start) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            // Divide by zero still occupies the unit but leaves HI/LO alone.
            pend_wr_d = ~(((op == MD_DIV) || (op == MD_DIVU)) && div_zero);
        end

        if (commit && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end

        if (mt_wr) begin
            if (op == MD_MTHI) begin
                hi_d = E_A;
            end else begin
                lo_d = E_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: self-checking bench for md_sched (table vectors + scoreboard,
// plus hand-written flush / reset sequences). Honours MD_DIVZERO_FAST_EN.
module tb_md_sched;

    logic        clk;
    logic        reset;
    logic [2:0]  E_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_flush;
    logic        D_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int unsigned checks;
    int unsigned failures;

`ifdef MD_DIVZERO_FAST_EN
    localparam int unsigned DIVZ_CYC = 1;
`else
    localparam int unsigned DIVZ_CYC = 10;
`endif

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } sb_t;

    vec_t vecs[12];
    sb_t  sb_q[$];

    // Model of architectural HI/LO as last committed.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sched dut (
        .clk      (clk),
        .reset    (reset),
        .E_op     (E_op),
        .E_A      (E_A),
        .E_B      (E_B),
        .E_flush  (E_flush),
        .D_md_use (D_md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Issue one operation with D_md_use held, measure busy length, compare
    // the committed HI/LO against the scoreboard entry pushed at issue.
    task automatic run_vec(input vec_t v);
        sb_t         e;
        int unsigned cnt;
        logic        exp_stall;
        sb_q.push_back('{hi: v.hi, lo: v.lo, cyc: v.cyc});
        exp_stall = (v.op >= OP_MULT) && (v.op <= OP_DIVU);
        @(negedge clk);
        E_op = v.op; E_A = v.a; E_B = v.b; D_md_use = 1'b1;
        #1;
        chk({v.name, "_stall_issue"}, 64'(md_stall), 64'(exp_stall));
        @(posedge clk);
        #1;
        E_op = OP_NONE;
        cnt  = 0;
        while (busy && cnt < 40) begin
            chk({v.name, "_stall_busy"}, 64'(md_stall), 64'd1);
            chk({v.name, "_no_early_commit"}, {HI, LO}, {m_hi, m_lo});
            cnt++;
            @(posedge clk);
            #1;
        end
        chk({v.name, "_stall_after"}, 64'(md_stall), 64'd0);
        e = sb_q.pop_front();
        chk({v.name, "_busy_cycles"}, 64'(cnt), 64'(e.cyc));
        chk({v.name, "_HI"}, 64'(HI), 64'(e.hi));
        chk({v.name, "_LO"}, 64'(LO), 64'(e.lo));
        m_hi = e.hi;
        m_lo = e.lo;
        D_md_use = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        checks   = 0;
        failures = 0;
        m_hi     = '0;
        m_lo     = '0;

        vecs[0]  = '{"mult_neg",   OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1]  = '{"multu",      OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{"div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{"divu",       OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4]  = '{"div_zero",   OP_DIV,   32'd5,         32'd0,         32'd1,         32'd3,         DIVZ_CYC};
        vecs[5]  = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[6]  = '{"divu_big",   OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999, 10};
        vecs[7]  = '{"divu_zero",  OP_DIVU,  32'd9,         32'd0,         32'd5,         32'h1999_9999, DIVZ_CYC};
        vecs[8]  = '{"mult_max",   OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[9]  = '{"div_negdiv", OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[10] = '{"mthi",       OP_MTHI,  32'h0000_AAAA, 32'd0,         32'h0000_AAAA, 32'hFFFF_FFFD, 0};
        vecs[11] = '{"mtlo",       OP_MTLO,  32'h0000_5555, 32'd0,         32'h0000_AAAA, 32'h0000_5555, 0};

        reset = 1'b1; E_op = OP_NONE; E_A = '0; E_B = '0; E_flush = 1'b0; D_md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_HI", 64'(HI), 64'd0);
        chk("reset_LO", 64'(LO), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(md_stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Flushed mthi must not touch HI.
        @(negedge clk);
        E_op = OP_MTHI; E_A = 32'h0000_1234; E_flush = 1'b1;
        @(posedge clk);
        #1;
        E_op = OP_NONE; E_flush = 1'b0;
        chk("mthi_flush_HI", 64'(HI), 64'(m_hi));
        chk("mthi_flush_busy", 64'(busy), 64'd0);

        // Flushed mult must not start.
        @(negedge clk);
        E_op = OP_MULT; E_A = 32'd3; E_B = 32'd4; E_flush = 1'b1;
        @(posedge clk);
        #1;
        E_op = OP_NONE; E_flush = 1'b0;
        chk("mult_flush_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("mult_flush_LO", 64'(LO), 64'(m_lo));

        // Flush arriving after the start cycle does not cancel the running op.
        sb_q.push_back('{hi: 32'd0, lo: 32'd12, cyc: 5});
        @(negedge clk);
        E_op = OP_MULT; E_A = 32'd3; E_B = 32'd4;
        @(posedge clk);
        #1;
        E_flush = 1'b1;
        @(posedge clk);
        #1;
        E_op = OP_NONE; E_flush = 1'b0;
        cnt = 2;
        while (busy && cnt < 40) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        begin
            sb_t e;
            e = sb_q.pop_front();
            chk("late_flush_cycles", 64'(cnt - 1), 64'(e.cyc));
            chk("late_flush_HI", 64'(HI), 64'(e.hi));
            chk("late_flush_LO", 64'(LO), 64'(e.lo));
            m_hi = e.hi;
            m_lo = e.lo;
        end

        // Reset during busy cycle 3 of a div abandons it.
        @(negedge clk);
        E_op = OP_DIV; E_A = 32'd100; E_B = 32'd7; D_md_use = 1'b0;
        @(posedge clk);
        #1;
        E_op = OP_NONE;
        chk("div_busy_nouse_stall", 64'(md_stall), 64'd0);
        chk("div_busy_c1", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_HI", 64'(HI), 64'd0);
        chk("rst_mid_LO", 64'(LO), 64'd0);
        cnt = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (busy || HI != 0 || LO != 0) cnt++;
        end
        chk("rst_no_late_commit", 64'(cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
